serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor that computes D = A − B, LSB-first, one bit per clock.
- Datapath is a single full-subtractor cell with a borrow flip-flop: the inverse counterpart of the FA/HA adder cells.
- Sits beside the adder blocks as the area-minimal subtract unit. A START/BUSY/DONE handshake lets a controller issue operations and collect results.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
START  input  1  request: sample A and B and begin an operation
A  input  WIDTH  minuend, sampled only on an accepted START
B  input  WIDTH  subtrahend, sampled only on an accepted START
BUSY  output  1  high while an operation is in progress
DONE  output  1  one-cycle pulse: result registers just updated
D  output  WIDTH  difference A − B mod 2^WIDTH
BOUT  output  1  final borrow; 1 iff A < B unsigned
V  output  1  signed overflow of A − B
Z  output  1  1 iff D == 0

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- RST sampled high at an edge:
  - state ← IDLE
  - BUSY=0, DONE=0, D=0, BOUT=0, V=0, Z=0
  - internal shift registers, borrow FF and bit counter cleared
  - RST has priority over everything, including mid-operation; the in-flight operation is discarded and no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - BUSY=0, DONE=0.
  - START=1 at edge → load SA←A, SB←B, borrow←0, cnt←0, state←RUN.
- RUN (BUSY=1, DONE=0), per edge:
  - a=SA[0], b=SB[0], br=borrow
  - diff bit = a ^ b ^ br
  - borrow ← (~a & b) | (~(a ^ b) & br)
  - SR ← {diff, SR[WIDTH-1:1]}; SA and SB shift right by 1; cnt ← cnt+1
  - On the edge processing bit WIDTH-1 (cnt == WIDTH-1):
    - D ← final shifted SR
    - BOUT ← final borrow
    - V ← (A_msb ≠ B_msb) & (D_msb ≠ A_msb), using the latched operand MSBs
    - Z ← (D == 0)
    - state ← FIN
- FIN:
  - DONE=1, BUSY=0 for exactly one cycle.
  - Next edge: START=1 → accepted exactly as in IDLE (back-to-back operation, no idle gap); else → IDLE.
- Latency: START sampled at edge k → BUSY=1 during cycles k+1 … k+WIDTH → DONE=1 in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- START while BUSY=1 is ignored; A and B are not resampled.
- D, BOUT, V and Z are registered. They change only on the FIN-entry edge or on reset, and hold between operations, including during a subsequent RUN.
- A and B are don't-care except at the accepting edge.
- Counter is $clog2(WIDTH)+1 bits; no wrap possible within an operation.
- Arithmetic is modulo 2^WIDTH; BOUT is the unsigned borrow and V the signed overflow, reported independently.

Test Plan (WIDTH=8):
1. A=0x5A, B=0x3C, START pulse → DONE in 9th cycle after START edge; D=0x1E, BOUT=0, V=0, Z=0; BUSY high exactly 8 cycles.
2. A=0x10, B=0x20 → D=0xF0, BOUT=1, V=0, Z=0. Then A=0x80, B=0x01 → D=0x7F, BOUT=0, V=1.
3. A=0x37, B=0x37 → D=0x00, Z=1, BOUT=0. Then A=0x00, B=0xFF → D=0x01, BOUT=1, V=0.
4. Start 0x5A−0x3C, then assert START with A=0xFF, B=0x00 on the 3rd BUSY cycle → ignored. Result D=0x1E; only one DONE pulse; BUSY not extended.
5. START held high continuously, with a new A/B presented in each FIN cycle → back-to-back results, DONE pulses every 9 cycles, D correct for each pair.
6. RST on the 4th BUSY cycle → next cycle BUSY=0, DONE=0, D=0, BOUT=V=Z=0; no DONE follows. A fresh START then completes normally (0x5A−0x3C → 0x1E).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Request/result bundle between a controller and serial_subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             V;
  logic             Z;

  modport master (
    output START, A, B,
    input  BUSY, DONE, D, BOUT, V, Z
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, D, BOUT, V, Z
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial D = A - B, LSB first, one full-subtractor cell plus a
//            borrow flop, with START/BUSY/DONE handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              bout_q, bout_d;
  logic              v_q, v_d;
  logic              z_q, z_d;

  logic              a_bit, b_bit, diff_bit, borrow_nxt;
  logic [WIDTH-1:0]  sr_shift;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    v_d      = v_q;
    z_d      = z_q;

    a_bit      = sa_q[0];
    b_bit      = sb_q[0];
    diff_bit   = a_bit ^ b_bit ^ borrow_q;
    borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    sr_shift   = {diff_bit, sr_q[WIDTH-1:1]};

    unique case (state_q)
      S_IDLE, S_FIN: begin
        // FIN accepts a new request directly so back-to-back ops have no gap
        if (bus.START) begin
          sa_d     = bus.A;
          sb_d     = bus.B;
          a_msb_d  = bus.A[WIDTH-1];
          b_msb_d  = bus.B[WIDTH-1];
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        sr_d     = sr_shift;
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          d_d     = sr_shift;
          bout_d  = borrow_nxt;
          // Operand MSBs were latched at load; the shifters no longer hold them
          v_d     = (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
          z_d     = (sr_shift == '0);
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.D    = d_q;
  assign bus.BOUT = bout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one accepted START; returns positioned in the first cycle after it.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.START = 1'b0;
    bus.A     = 8'hxx;
    bus.B     = 8'hxx;
  endtask

  // Count cycles (current one = 1) until DONE, bounded; also tallies BUSY.
  task automatic wait_done(output int n, output int busy_cnt);
    n        = 1;
    busy_cnt = 0;
    while (1) begin
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE || n >= 40) break;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.BUSY, bus.DONE, bus.D, bus.BOUT, bus.V, bus.Z} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b d=%h bout=%b v=%b z=%b exp all 0",
               bus.BUSY, bus.DONE, bus.D, bus.BOUT, bus.V, bus.Z);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n, bc;
    start_op(8'h5A, 8'h3C);
    wait_done(n, bc);
    total++;
    if (n !== 9) begin bad++; $display("FAIL basic_latency: got %0d exp 9", n); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d exp 8", bc); end
    total++;
    if ({bus.D, bus.BOUT, bus.V, bus.Z} !== {8'h1E, 3'b000}) begin
      bad++;
      $display("FAIL basic_result: got d=%h bout=%b v=%b z=%b exp d=1e bout=0 v=0 z=0",
               bus.D, bus.BOUT, bus.V, bus.Z);
    end
    tick();
    total++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b exp 0 0", bus.DONE, bus.BUSY);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va[5] = '{8'h10, 8'h80, 8'h37, 8'h00, 8'h7F};
    logic [7:0] vb[5] = '{8'h20, 8'h01, 8'h37, 8'hFF, 8'hFF};
    logic [7:0] vd[5] = '{8'hF0, 8'h7F, 8'h00, 8'h01, 8'h80};
    logic [2:0] vf[5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b110}; // {bout,v,z}
    int n, bc;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      wait_done(n, bc);
      total++;
      if (n !== 9 || bus.D !== vd[i] || {bus.BOUT, bus.V, bus.Z} !== vf[i]) begin
        bad++;
        $display("FAIL vector_%0d: got n=%0d d=%h bvz=%b exp n=9 d=%h bvz=%b",
                 i, n, bus.D, {bus.BOUT, bus.V, bus.Z}, vd[i], vf[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int busy_cnt = 0, done_cnt = 0, done_at = 0;
    logic [7:0] d_at_done = 8'h00;
    start_op(8'h5A, 8'h3C);
    for (int i = 1; i <= 20; i++) begin
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) begin done_cnt++; done_at = i; d_at_done = bus.D; end
      if (i == 3) begin bus.START = 1'b1; bus.A = 8'hFF; bus.B = 8'h00; end
      if (i == 4) bus.START = 1'b0;
      tick();
    end
    total++;
    if (done_cnt !== 1 || done_at !== 9) begin
      bad++;
      $display("FAIL busy_ignore_done: got count=%0d at=%0d exp 1 at 9", done_cnt, done_at);
    end
    total++;
    if (busy_cnt !== 8) begin bad++; $display("FAIL busy_ignore_len: got %0d exp 8", busy_cnt); end
    total++;
    if (d_at_done !== 8'h1E) begin
      bad++;
      $display("FAIL busy_ignore_d: got %h exp 1e", d_at_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[3] = '{8'h5A, 8'h10, 8'h80};
    logic [7:0] pb[3] = '{8'h3C, 8'h20, 8'h01};
    logic [7:0] pd[3] = '{8'h1E, 8'hF0, 8'h7F};
    int ndone = 0;
    bus.START = 1'b1;
    bus.A = pa[0];
    bus.B = pb[0];
    tick();
    for (int i = 1; i <= 40 && ndone < 3; i++) begin
      if (bus.DONE) begin
        total++;
        if (i !== 9 * (ndone + 1) || bus.D !== pd[ndone]) begin
          bad++;
          $display("FAIL b2b_result_%0d: got cycle=%0d d=%h exp cycle=%0d d=%h",
                   ndone, i, bus.D, 9 * (ndone + 1), pd[ndone]);
        end
        ndone++;
        if (ndone < 3) begin bus.A = pa[ndone]; bus.B = pb[ndone]; end
        else bus.START = 1'b0;
      end else if (ndone > 0 && i == 9 * ndone + 1) begin
        total++;
        if (bus.BUSY !== 1'b1 || bus.D !== pd[ndone-1]) begin
          bad++;
          $display("FAIL b2b_hold_%0d: got busy=%b d=%h exp busy=1 d=%h",
                   ndone, bus.BUSY, bus.D, pd[ndone-1]);
        end
      end
      tick();
    end
    bus.START = 1'b0;
    total++;
    if (ndone !== 3) begin bad++; $display("FAIL b2b_count: got %0d exp 3", ndone); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int stray = 0, n, bc;
    start_op(8'h5A, 8'h3C);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.BUSY, bus.DONE, bus.D, bus.BOUT, bus.V, bus.Z} !== 12'h000) begin
      bad++;
      $display("FAIL midrst_state: got busy=%b done=%b d=%h bout=%b v=%b z=%b exp all 0",
               bus.BUSY, bus.DONE, bus.D, bus.BOUT, bus.V, bus.Z);
    end
    for (int i = 0; i < 15; i++) begin
      if (bus.DONE || bus.BUSY) stray++;
      tick();
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d active cycles exp 0", stray); end
    start_op(8'h5A, 8'h3C);
    wait_done(n, bc);
    total++;
    if (n !== 9 || bus.D !== 8'h1E || {bus.BOUT, bus.V, bus.Z} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_restart: got n=%0d d=%h bvz=%b exp n=9 d=1e bvz=000",
               n, bus.D, {bus.BOUT, bus.V, bus.Z});
    end
    tick();
  endtask

  initial begin
    bus.START = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    test_reset();
    test_basic();
    test_vectors();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
